ether_bus_decode: RTL
=====================

// Module: ether_bus_decode
//
// PURPOSE
//  Downstream of the Ethernet aggregator. Takes each 56-bit aggregated payload,
//  which arrives with a single-cycle valid, and decodes it into a bus transaction
//  (rw, addr, data). The decoded transaction goes into a small FIFO, and the FIFO
//  is drained onto the core bus under a valid/ready handshake.
//  The block drops malformed payloads, retransmitted duplicates and overflowing
//  payloads, and counts both accepted and dropped payloads.
//
// PARAMETERS
//  FIFO_DEPTH  4      transaction FIFO entries; power of 2, >= 2
//  CMD_READ    8'h00  command byte decoded as a read (rw=0)
//  CMD_WRITE   8'h01  command byte decoded as a write (rw=1)
//
// PORTS
//  clk           in   1   system clock; all state changes on its rising edge
//  rst_n         in   1   asynchronous, active-low reset
//  axiid         in   56  aggregated payload: [55:48] cmd, [47:32] addr, [31:16] data, [15:0] seq
//  axiiv         in   1   payload valid; single-cycle pulse, no backpressure
//  bus_rw_o      out  1   head transaction: 1=write, 0=read
//  bus_addr_o    out  16  head transaction address
//  bus_data_o    out  16  head transaction write data (passed through unchanged for reads)
//  bus_valid_o   out  1   FIFO non-empty; a head transaction is presented
//  bus_ready_i   in   1   consumer accepts the head when bus_valid_o && bus_ready_i
//  fifo_full_o   out  1   FIFO holds FIFO_DEPTH entries
//  accept_cnt_o  out  16  payloads accepted into FIFO; saturates at 16'hFFFF
//  drop_cnt_o    out  16  payloads dropped (any cause); saturates at 16'hFFFF
//
// BEHAVIOUR
//  Reset (async assert, sync deassert handled upstream):
//   - Clears FIFO pointers/occupancy, both counters and the last-seq-valid flag.
//   - All outputs 0 while rst_n=0; an in-flight payload is lost and not counted.
//  Classification, on the axiiv cycle N, evaluated in priority order:
//   1. cmd not CMD_READ/CMD_WRITE -> drop.
//   2. last_seq_vld && seq==last_seq -> drop (duplicate).
//   3. fifo_full_o==1 at cycle N -> drop. Pops in cycle N do NOT free a slot for N.
//   4. Otherwise accept: push {rw,addr,data}; last_seq<=seq; last_seq_vld<=1.
//  Only accepts update last_seq; a full-drop leaves it, so a retransmit is taken later.
//  Counters:
//   - Exactly one counter increments per axiiv pulse, at the edge ending cycle N.
//   - Saturating; no wrap.
//  Latency:
//   - Accept in cycle N -> entry visible at FIFO tail from N+1.
//   - If FIFO was empty, bus_valid_o=1 with that entry's fields in cycle N+1.
//  Handshake:
//   - Pop on bus_valid_o && bus_ready_i.
//   - Outputs stay stable while bus_valid_o && !bus_ready_i.
//   - Outputs drive registered FIFO head; no combinational path from axiiv to bus_*.
//  Simultaneous push and pop:
//   - Non-full FIFO: push and pop in the same cycle leave occupancy unchanged.
//   - Empty FIFO: no pop is possible in the push cycle.
//  Pointers: log2(FIFO_DEPTH) bits plus one extra wrap bit. Full/empty come from the
//   registered pointers; wrap-around is seamless.
//  axiiv while rst_n=0: ignored.
//
// TESTING
//  1. Reset, then one valid write {01,1234,ABCD,0001}, ready=1
//     -> bus_valid_o=1 exactly 1 cycle at N+1, rw=1 addr=1234 data=ABCD; accept=1, drop=0.
//  2. Same seq sent twice (0005,0005), then seq 0006
//     -> 2 transactions out; drop=1; accept=2.
//  3. cmd=8'h7F -> no transaction; drop_cnt_o=1; last_seq unchanged.
//  4. ready=0, send FIFO_DEPTH+1 distinct payloads
//     -> fifo_full_o=1; drop=1; raise ready: FIFO_DEPTH transactions in order.
//  5. Full FIFO, payload arrives in the same cycle as a pop
//     -> payload dropped; occupancy=DEPTH-1.
//     Resend the same seq -> accepted.
//  6. Assert rst_n=0 with 3 entries queued
//     -> bus_valid_o=0 and counters 0 immediately; seq 0001 is accepted after release.

Source files
------------

// File: rtl/ether_bus_decode.sv
// rtl/ether_bus_decode.sv - decode aggregated Ethernet payloads into bus transactions
// Classifies each payload (malformed/duplicate/overflow drop) and queues accepts in a FIFO.
module ether_bus_decode #(
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] CMD_READ   = 8'h00,
  parameter logic [7:0] CMD_WRITE  = 8'h01
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [55:0] axiid,
  input  logic        axiiv,
  output logic        bus_rw_o,
  output logic [15:0] bus_addr_o,
  output logic [15:0] bus_data_o,
  output logic        bus_valid_o,
  input  logic        bus_ready_i,
  output logic        fifo_full_o,
  output logic [15:0] accept_cnt_o,
  output logic [15:0] drop_cnt_o
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [32:0] mem [FIFO_DEPTH];
  logic [AW:0] wptr, rptr;
  logic [15:0] last_seq;
  logic        last_seq_vld;

  logic [7:0]  cmd;
  logic [15:0] addr, data, seq;
  logic        empty, full, cmd_ok, dup, accept, drop, pop;
  logic [32:0] head;

  assign cmd  = axiid[55:48];
  assign addr = axiid[47:32];
  assign data = axiid[31:16];
  assign seq  = axiid[15:0];

  // Extra wrap bit distinguishes full from empty when the index bits match.
  assign empty  = (wptr == rptr);
  assign full   = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign cmd_ok = (cmd == CMD_READ) || (cmd == CMD_WRITE);
  assign dup    = last_seq_vld && (seq == last_seq);
  assign accept = axiiv && cmd_ok && !dup && !full;
  assign drop   = axiiv && !accept;
  assign pop    = !empty && bus_ready_i;

  assign head        = mem[rptr[AW-1:0]];
  assign bus_valid_o = !empty;
  assign bus_rw_o    = bus_valid_o & head[32];
  assign bus_addr_o  = bus_valid_o ? head[31:16] : 16'h0000;
  assign bus_data_o  = bus_valid_o ? head[15:0]  : 16'h0000;
  assign fifo_full_o = full;

  always_ff @(posedge clk) begin
    if (accept) mem[wptr[AW-1:0]] <= {(cmd == CMD_WRITE), addr, data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr         <= '0;
      rptr         <= '0;
      last_seq     <= 16'h0000;
      last_seq_vld <= 1'b0;
      accept_cnt_o <= 16'h0000;
      drop_cnt_o   <= 16'h0000;
    end else begin
      if (accept) begin
        wptr         <= wptr + 1'b1;
        last_seq     <= seq;
        last_seq_vld <= 1'b1;
        if (accept_cnt_o != 16'hFFFF) accept_cnt_o <= accept_cnt_o + 16'd1;
      end
      if (drop && (drop_cnt_o != 16'hFFFF)) drop_cnt_o <= drop_cnt_o + 16'd1;
      if (pop) rptr <= rptr + 1'b1;
    end
  end

endmodule
